givens_rotator: RTL and testbench

- Sits directly downstream of sin_cos. Consumes each (cos, sin) pair it produces and applies the Givens rotation to a row pair of ROW_LEN elements streamed in as (x_i, y_i).
- Outputs the rotated pairs to the matrix write-back stage.
- Buffers angles because sin_cos has no backpressure. Element input and output use valid/ready.

---
 rtl/givens_rotator.sv | 254 +++++++++++++++++++++++++
 tb/tb_givens_rotator.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/givens_rotator.sv
// givens_rotator: applies a Givens rotation (cos, sin) to ROW_LEN streamed
// element pairs per angle.
//   x' = (c*x + s*y) >>> CS_FRAC,  y' = (c*y - s*x) >>> CS_FRAC
// Angles arrive as unacknowledged pulses from sin_cos and are buffered in a
// 2-entry FIFO. Element input and output use valid/ready. Two pipeline stages
// give a fixed latency: the pair accepted in cycle k is valid in cycle k+2.
//
// Optional build macro GIVENS_SAT_EN: when defined, results saturate to the
// signed DATA_W range; when undefined, results wrap (low DATA_W bits kept).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   cs_valid/cs_cos/cs_sin   angle pulse, signed fixed point (CS_FRAC frac bits)
//   in_valid/in_ready        element pair handshake, in_x/in_y signed
//   out_valid/out_ready      rotated pair handshake, out_x/out_y signed
//   out_last                 marks the ROW_LEN-th pair of each angle
//   busy                     rotating or pipeline holds data
//   angle_ovf                sticky: an angle was dropped on a full FIFO
module givens_rotator #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ROW_LEN = 4,
  parameter int unsigned CS_W    = 8,
  parameter int unsigned CS_FRAC = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_valid,
  input  logic [CS_W-1:0]   cs_cos,
  input  logic [CS_W-1:0]   cs_sin,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic              out_last,
  output logic              busy,
  output logic              angle_ovf
);

  localparam int unsigned PROD_W = DATA_W + CS_W;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam int unsigned CNT_W  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ROTATE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Angle FIFO
  logic [1:0][CS_W-1:0] fcos_q, fcos_d;
  logic [1:0][CS_W-1:0] fsin_q, fsin_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           fcnt_q, fcnt_d;
  logic                 ovf_q, ovf_d;

  // Stage 1
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_last_q, s1_last_d;
  logic signed [PROD_W-1:0] p_cx_q, p_cx_d;
  logic signed [PROD_W-1:0] p_sy_q, p_sy_d;
  logic signed [PROD_W-1:0] p_sx_q, p_sx_d;
  logic signed [PROD_W-1:0] p_cy_q, p_cy_d;

  // Stage 2 / outputs
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_x_q, out_x_d;
  logic [DATA_W-1:0] out_y_q, out_y_d;

  logic pipe_en_c, accept_c, last_c, push_c, pop_c, full_c;

  logic signed [CS_W-1:0]   cos_h, sin_h;
  logic signed [PROD_W-1:0] cos_e, sin_e, x_e, y_e;
  logic signed [SUM_W-1:0]  sum_x_c, sum_y_c, shx_c, shy_c;

  // Narrow a shifted sum to DATA_W: saturate or wrap depending on build.
  function automatic logic [DATA_W-1:0] reduce(input logic signed [SUM_W-1:0] v);
`ifdef GIVENS_SAT_EN
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    hi = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (v > hi)      return DATA_W'(hi);
    else if (v < lo) return DATA_W'(lo);
    else             return DATA_W'(v);
`else
    return DATA_W'(v);
`endif
  endfunction

  // Handshake and angle-queue control
  always_comb begin
    pipe_en_c = !out_valid_q || out_ready;
    in_ready  = (state_q == ST_ROTATE) && pipe_en_c;
    accept_c  = in_valid && in_ready;
    last_c    = accept_c && (cnt_q == CNT_W'(ROW_LEN - 1));
    pop_c     = last_c;
    full_c    = (fcnt_q == 2'd2);
    // A push into a full FIFO only succeeds when the head leaves this cycle.
    push_c    = cs_valid && (!full_c || pop_c);
  end

  // Angle FIFO update and row FSM
  always_comb begin
    fcos_d   = fcos_q;
    fsin_d   = fsin_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    ovf_d    = ovf_q;
    state_d  = state_q;
    cnt_d    = cnt_q;

    if (push_c) begin
      fcos_d[wr_ptr_q] = cs_cos;
      fsin_d[wr_ptr_q] = cs_sin;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop_c) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    fcnt_d = fcnt_q + 2'(push_c) - 2'(pop_c);
    if (cs_valid && !push_c) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (fcnt_q != 2'd0) begin
          state_d = ST_ROTATE;
        end
      end
      ST_ROTATE: begin
        if (accept_c) begin
          if (last_c) begin
            cnt_d = '0;
            // Next angle already waiting: keep rotating without a bubble.
            if (fcnt_d == 2'd0) begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage 1: the head angle travels with the pair as four products
  always_comb begin
    cos_h = fcos_q[rd_ptr_q];
    sin_h = fsin_q[rd_ptr_q];
    cos_e = PROD_W'(cos_h);
    sin_e = PROD_W'(sin_h);
    x_e   = PROD_W'($signed(in_x));
    y_e   = PROD_W'($signed(in_y));

    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    p_cx_d     = p_cx_q;
    p_sy_d     = p_sy_q;
    p_sx_d     = p_sx_q;
    p_cy_d     = p_cy_q;
    if (pipe_en_c) begin
      s1_valid_d = accept_c;
      s1_last_d  = last_c;
      if (accept_c) begin
        p_cx_d = cos_e * x_e;
        p_sy_d = sin_e * y_e;
        p_sx_d = sin_e * x_e;
        p_cy_d = cos_e * y_e;
      end
    end
  end

  // Stage 2: sum, floor-shift by CS_FRAC, narrow to DATA_W
  always_comb begin
    sum_x_c = SUM_W'(p_cx_q) + SUM_W'(p_sy_q);
    sum_y_c = SUM_W'(p_cy_q) - SUM_W'(p_sx_q);
    shx_c   = sum_x_c >>> CS_FRAC;
    shy_c   = sum_y_c >>> CS_FRAC;

    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    if (pipe_en_c) begin
      out_valid_d = s1_valid_q;
      out_last_d  = s1_last_q;
      if (s1_valid_q) begin
        out_x_d = reduce(shx_c);
        out_y_d = reduce(shy_c);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fcos_q      <= '0;
      fsin_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fcnt_q      <= '0;
      ovf_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      p_cx_q      <= '0;
      p_sy_q      <= '0;
      p_sx_q      <= '0;
      p_cy_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fcos_q      <= fcos_d;
      fsin_q      <= fsin_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
      ovf_q       <= ovf_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      p_cx_q      <= p_cx_d;
      p_sy_q      <= p_sy_d;
      p_sx_q      <= p_sx_d;
      p_cy_q      <= p_cy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign angle_ovf = ovf_q;
  assign busy      = (state_q == ST_ROTATE) || s1_valid_q || out_valid_q;

endmodule

// File: tb/tb_givens_rotator.sv
module tb_givens_rotator;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ROW_LEN = 4;
  localparam int unsigned CS_W    = 8;
  localparam int unsigned CS_FRAC = 6;

  logic              clk;
  logic              rst;
  logic              cs_valid;
  logic [CS_W-1:0]   cs_cos, cs_sin;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_x, in_y;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_x, out_y;
  logic              out_last, busy, angle_ovf;

  givens_rotator #(
    .DATA_W(DATA_W), .ROW_LEN(ROW_LEN), .CS_W(CS_W), .CS_FRAC(CS_FRAC)
  ) dut (
    .clk(clk), .rst(rst),
    .cs_valid(cs_valid), .cs_cos(cs_cos), .cs_sin(cs_sin),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_last(out_last), .busy(busy), .angle_ovf(angle_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: angle queue, row position, expected outputs
  int m_c[$];
  int m_s[$];
  int m_cnt = 0;
  int m_ovf = 0;
  int e_x[$];
  int e_y[$];
  int e_l[$];
  logic last_in_fire;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int reduce(input int v);
    int lim;
    int w;
    lim = 1 << (DATA_W - 1);
`ifdef GIVENS_SAT_EN
    w = v;
    if (v > lim - 1) w = lim - 1;
    if (v < -lim)    w = -lim;
`else
    w = v & ((1 << DATA_W) - 1);
    if (w >= lim) w = w - (1 << DATA_W);
`endif
    return w;
  endfunction

  function automatic void model_reset();
    m_c.delete(); m_s.delete();
    e_x.delete(); e_y.delete(); e_l.delete();
    m_cnt = 0;
    m_ovf = 0;
  endfunction

  // One clock: sample handshakes at the falling edge, advance the model,
  // score any output transfer, leave inputs drivable at posedge+1.
  task automatic tick();
    logic o_f, i_f, c_f, ol;
    logic signed [31:0] ox, oy;
    int ix, iy, cc, ss, c, s;
    @(negedge clk);
    o_f = out_valid && out_ready;
    ox  = $signed(out_x);
    oy  = $signed(out_y);
    ol  = out_last;
    i_f = in_valid && in_ready;
    ix  = $signed(in_x);
    iy  = $signed(in_y);
    c_f = cs_valid;
    cc  = $signed(cs_cos);
    ss  = $signed(cs_sin);
    @(posedge clk);
    #1;
    last_in_fire = i_f;
    if (i_f) begin
      if (m_c.size() == 0) begin
        check("accept_without_angle", 0, 1);
      end else begin
        c = m_c[0];
        s = m_s[0];
        e_x.push_back(reduce((c * ix + s * iy) >>> CS_FRAC));
        e_y.push_back(reduce((c * iy - s * ix) >>> CS_FRAC));
        e_l.push_back(m_cnt == ROW_LEN - 1);
        m_cnt++;
        if (m_cnt == ROW_LEN) begin
          m_cnt = 0;
          void'(m_c.pop_front());
          void'(m_s.pop_front());
        end
      end
    end
    if (c_f) begin
      if (m_c.size() < 2) begin
        m_c.push_back(cc);
        m_s.push_back(ss);
      end else begin
        m_ovf = 1;
      end
    end
    if (o_f) begin
      if (e_x.size() == 0) begin
        check("out_unexpected", 1, 0);
      end else begin
        check("out_x", ox, e_x.pop_front());
        check("out_y", oy, e_y.pop_front());
        check("out_last", ol, e_l.pop_front());
      end
    end
    check("angle_ovf", angle_ovf, m_ovf);
  endtask

  task automatic pulse(input logic [CS_W-1:0] c, input logic [CS_W-1:0] s);
    cs_valid = 1'b1;
    cs_cos   = c;
    cs_sin   = s;
    tick();
    cs_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10 && !in_ready; i++) tick();
    check("rotate_entered", in_ready, 1);
  endtask

  // Present one pair until accepted; n returns the number of clocks used.
  task automatic send_pair(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                           output int n);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    n        = 0;
    do begin
      tick();
      n++;
    end while (!last_in_fire && n < 50);
    check("send_accept", last_in_fire, 1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (e_x.size() != 0 || out_valid); i++) tick();
    check("drain_empty", e_x.size(), 0);
  endtask

  initial begin
    int n;
    logic [DATA_W-1:0] held_x, held_y;

    rst = 1'b1; cs_valid = 1'b0; cs_cos = '0; cs_sin = '0;
    in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
    last_in_fire = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_angle_ovf", angle_ovf, 0);
    rst = 1'b0;
    tick();

    // Identity rotation with latency check
    pulse(8'h40, 8'h00);
    wait_ready();
    in_valid = 1'b1; in_x = 8'sd5; in_y = -8'sd3;
    tick();
    check("lat_accept", last_in_fire, 1);
    check("lat_stage1", out_valid, 0);
    in_x = 8'sd127; in_y = -8'sd128;
    tick();
    check("lat_out", out_valid, 1);
    in_x = 8'sd0; in_y = 8'sd1;
    tick();
    in_x = -8'sd1; in_y = -8'sd1;
    tick();
    drain();
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 0);

    // 90 degrees
    pulse(8'h00, 8'h40);
    send_pair(8'sd10, 8'sd20, n);
    send_pair(-8'sd128, 8'sd0, n);
    send_pair(8'($urandom), 8'($urandom), n);
    send_pair(8'($urandom), 8'($urandom), n);
    drain();

    // 45 degrees, floor truncation
    pulse(8'h2D, 8'h2D);
    send_pair(8'sd100, 8'sd0, n);
    for (int i = 0; i < 3; i++) send_pair(8'($urandom), 8'($urandom), n);
    drain();

    // Saturation / wrap
    pulse(8'h40, 8'h40);
    send_pair(8'sd100, 8'sd100, n);
    for (int i = 0; i < 3; i++) send_pair(8'($urandom), 8'($urandom), n);
    drain();

    // Angle queue overflow, then two back-to-back rows
    pulse(8'($urandom), 8'($urandom));
    pulse(8'($urandom), 8'($urandom));
    pulse(8'($urandom), 8'($urandom));
    check("ovf_set", angle_ovf, 1);
    for (int i = 0; i < 2 * ROW_LEN; i++) begin
      send_pair(8'($urandom), 8'($urandom), n);
      check("no_bubble", n, 1);
    end
    drain();
    check("two_rows_idle", busy, 0);

    // Backpressure mid-row
    pulse(8'($urandom), 8'($urandom));
    wait_ready();
    send_pair(8'($urandom), 8'($urandom), n);
    send_pair(8'($urandom), 8'($urandom), n);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_x = 8'($urandom); in_y = 8'($urandom);
    held_x = out_x;
    held_y = out_y;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_hold_x", out_x, held_x);
      check("stall_hold_y", out_y, held_y);
    end
    out_ready = 1'b1;
    send_pair(in_x, in_y, n);
    send_pair(8'($urandom), 8'($urandom), n);
    drain();

    // Reset mid-row
    pulse(8'($urandom), 8'($urandom));
    wait_ready();
    send_pair(8'($urandom), 8'($urandom), n);
    send_pair(8'($urandom), 8'($urandom), n);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_x", out_x, 0);
    check("mid_rst_out_y", out_y, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", angle_ovf, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_fifo_empty", busy, 0);
    pulse(8'h40, 8'h00);
    for (int i = 0; i < ROW_LEN; i++) send_pair(8'($urandom), 8'($urandom), n);
    drain();

    // Random traffic: sporadic angles, gaps and backpressure
    for (int i = 0; i < 300; i++) begin
      cs_valid  = ($urandom_range(7) == 0);
      cs_cos    = 8'($urandom);
      cs_sin    = 8'($urandom);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      tick();
      if (last_in_fire) begin
        in_x = 8'($urandom);
        in_y = 8'($urandom);
      end
    end
    cs_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
